// File: rtl/icb_2m1s_arb_pkg.sv
// icb_2m1s_arb_pkg: shared ICB widths, FSM state encoding and command bundle for the 2-master arbiter
//   MemAddrBus / MemBus / MemMask : address, data and byte-mask widths of the ICB port
//   arb_state_e                   : ARB (grant/forward), WAIT_RSP (one outstanding), TO_RSP (watchdog error)
//   icb_cmd_t                     : packed command fields, muxed as one unit
//   timer_w()                     : watchdog counter width, at least one bit even when the watchdog is off
package icb_2m1s_arb_pkg;
  localparam int MemAddrBus = 32;
  localparam int MemBus = 32;
  localparam int MemMask = MemBus / 8;
  typedef enum logic [1:0] {
    ARB_S_ARB      = 2'd0,
    ARB_S_WAIT_RSP = 2'd1,
    ARB_S_TO_RSP   = 2'd2
  } arb_state_e;
  typedef struct packed {
    logic [MemAddrBus-1:0] addr;
    logic                  read;
    logic [MemBus-1:0]     wdata;
    logic [MemMask-1:0]    wmask;
  } icb_cmd_t;
  function automatic int unsigned timer_w(input int unsigned cyc);
    return (cyc > 0) ? $clog2(cyc + 1) : 1;
  endfunction
endpackage

// File: rtl/icb_2m1s_arb_rr_arb2.sv
// icb_2m1s_arb_rr_arb2: two-requester round-robin picker with a hold (lock) override
//   req_i   : request vector, bit 0 = master 0, bit 1 = master 1
//   last_i  : master served most recently; loses a tie
//   lock_i  : a command is pending at the slave, keep granting owner_i
//   owner_i : master holding the pending command
//   gnt_o   : granted master index (0 when nobody requests)
module icb_2m1s_arb_rr_arb2
  import icb_2m1s_arb_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       last_i,
  input  logic       lock_i,
  input  logic       owner_i,
  output logic       gnt_o
);
  always_comb gnt_o = lock_i ? owner_i : (&req_i) ? ~last_i : req_i[1];
endmodule

// File: rtl/icb_2m1s_arb.sv
// icb_2m1s_arb: two-master / one-slave ICB arbiter, round-robin, single outstanding, response watchdog
//   clk, rst_n        : system clock, asynchronous active-low reset
//   m0_icb_* (JTAG)   : master 0 cmd (valid/ready/addr/read/wdata/wmask) and rsp (valid/ready/err/rdata)
//   m1_icb_* (core)   : master 1, same set as master 0
//   s_icb_*           : shared slave port, command forwarded and response returned combinationally
//   timeout_o         : one-cycle pulse when the slave fails to answer within TIMEOUT_CYC cycles
module icb_2m1s_arb
  import icb_2m1s_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 1023
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  m0_icb_cmd_valid,
  output logic                  m0_icb_cmd_ready,
  input  logic [MemAddrBus-1:0] m0_icb_cmd_addr,
  input  logic                  m0_icb_cmd_read,
  input  logic [MemBus-1:0]     m0_icb_cmd_wdata,
  input  logic [MemMask-1:0]    m0_icb_cmd_wmask,
  output logic                  m0_icb_rsp_valid,
  input  logic                  m0_icb_rsp_ready,
  output logic                  m0_icb_rsp_err,
  output logic [MemBus-1:0]     m0_icb_rsp_rdata,
  input  logic                  m1_icb_cmd_valid,
  output logic                  m1_icb_cmd_ready,
  input  logic [MemAddrBus-1:0] m1_icb_cmd_addr,
  input  logic                  m1_icb_cmd_read,
  input  logic [MemBus-1:0]     m1_icb_cmd_wdata,
  input  logic [MemMask-1:0]    m1_icb_cmd_wmask,
  output logic                  m1_icb_rsp_valid,
  input  logic                  m1_icb_rsp_ready,
  output logic                  m1_icb_rsp_err,
  output logic [MemBus-1:0]     m1_icb_rsp_rdata,
  output logic                  s_icb_cmd_valid,
  input  logic                  s_icb_cmd_ready,
  output logic [MemAddrBus-1:0] s_icb_cmd_addr,
  output logic                  s_icb_cmd_read,
  output logic [MemBus-1:0]     s_icb_cmd_wdata,
  output logic [MemMask-1:0]    s_icb_cmd_wmask,
  input  logic                  s_icb_rsp_valid,
  output logic                  s_icb_rsp_ready,
  input  logic                  s_icb_rsp_err,
  input  logic [MemBus-1:0]     s_icb_rsp_rdata,
  output logic                  timeout_o
);
  localparam int unsigned TW = timer_w(TIMEOUT_CYC);
  localparam logic [TW-1:0] TLIM = TW'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

  arb_state_e    state_q, state_d;
  logic          owner_q, owner_d;
  logic          last_q, last_d;
  logic          lock_q, lock_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          gnt;
  logic          own_rsp_ready;
  logic          to_fire;
  logic          rsp_vld;
  logic          to_st;
  icb_cmd_t      m0_cmd, m1_cmd;

  assign m0_cmd = {m0_icb_cmd_addr, m0_icb_cmd_read, m0_icb_cmd_wdata, m0_icb_cmd_wmask};
  assign m1_cmd = {m1_icb_cmd_addr, m1_icb_cmd_read, m1_icb_cmd_wdata, m1_icb_cmd_wmask};
  assign own_rsp_ready = owner_q ? m1_icb_rsp_ready : m0_icb_rsp_ready;
  assign to_st = (state_q == ARB_S_TO_RSP);
  // A real response arriving on the last count beats the watchdog.
  assign to_fire = (TIMEOUT_CYC != 0) && (state_q == ARB_S_WAIT_RSP) && (timer_q == TLIM) && !s_icb_rsp_valid;

  icb_2m1s_arb_rr_arb2 u_rr_arb2 (
    .req_i  ({m1_icb_cmd_valid, m0_icb_cmd_valid}),
    .last_i (last_q),
    .lock_i (lock_q),
    .owner_i(owner_q),
    .gnt_o  (gnt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ARB_S_ARB;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      lock_q  <= 1'b0;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      lock_q  <= lock_d;
      timer_q <= timer_d;
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    lock_d  = lock_q;
    timer_d = timer_q;
    if (state_q == ARB_S_ARB) begin
      // Freeze the grant while the slave back-pressures; a dropped valid releases it.
      lock_d  = s_icb_cmd_valid & ~s_icb_cmd_ready;
      owner_d = s_icb_cmd_valid ? gnt : owner_q;
      if (s_icb_cmd_valid && s_icb_cmd_ready) begin
        last_d  = gnt;
        timer_d = '0;
        state_d = ARB_S_WAIT_RSP;
      end
    end else if (state_q == ARB_S_WAIT_RSP) begin
      // Saturate so a held-but-unaccepted response cannot wrap the counter.
      timer_d = (timer_q == TLIM) ? timer_q : timer_q + 1'b1;
      state_d = (s_icb_rsp_valid && own_rsp_ready) ? ARB_S_ARB :
                to_fire ? ARB_S_TO_RSP : ARB_S_WAIT_RSP;
    end else if (state_q == ARB_S_TO_RSP) begin
      state_d = own_rsp_ready ? ARB_S_ARB : ARB_S_TO_RSP;
    end else begin
      state_d = ARB_S_ARB;
    end
  end

  always_comb begin
    s_icb_cmd_valid = (state_q == ARB_S_ARB) & (gnt ? m1_icb_cmd_valid : m0_icb_cmd_valid);
    {s_icb_cmd_addr, s_icb_cmd_read, s_icb_cmd_wdata, s_icb_cmd_wmask} = gnt ? m1_cmd : m0_cmd;
    m0_icb_cmd_ready = s_icb_cmd_valid & ~gnt & s_icb_cmd_ready;
    m1_icb_cmd_ready = s_icb_cmd_valid & gnt & s_icb_cmd_ready;
    // Outside WAIT_RSP the slave response is always accepted and dropped.
    s_icb_rsp_ready  = (state_q == ARB_S_WAIT_RSP) ? own_rsp_ready : 1'b1;
    rsp_vld          = (state_q == ARB_S_WAIT_RSP) ? s_icb_rsp_valid : to_st;
    m0_icb_rsp_valid = rsp_vld & ~owner_q;
    m1_icb_rsp_valid = rsp_vld & owner_q;
    m0_icb_rsp_err   = to_st | s_icb_rsp_err;
    m1_icb_rsp_err   = to_st | s_icb_rsp_err;
    m0_icb_rsp_rdata = to_st ? '0 : s_icb_rsp_rdata;
    m1_icb_rsp_rdata = to_st ? '0 : s_icb_rsp_rdata;
    timeout_o        = to_fire;
  end
endmodule

// File: tb/tb_icb_2m1s_arb.sv
// tb_icb_2m1s_arb: scoreboard bench for icb_2m1s_arb (slave model echoes addr as rdata, addr[0] as err)
module tb_icb_2m1s_arb;
  localparam int unsigned TO = 8;
  typedef struct packed {logic [31:0] addr; logic read; logic [31:0] wdata; logic [3:0] wmask;} cmd_t;
  typedef struct packed {logic err; logic [31:0] rdata;} rsp_t;

  logic clk = 0, rst_n = 0;
  logic m0_icb_cmd_valid, m0_icb_cmd_ready, m0_icb_cmd_read, m0_icb_rsp_valid, m0_icb_rsp_ready, m0_icb_rsp_err;
  logic [31:0] m0_icb_cmd_addr, m0_icb_cmd_wdata, m0_icb_rsp_rdata;
  logic [3:0] m0_icb_cmd_wmask;
  logic m1_icb_cmd_valid, m1_icb_cmd_ready, m1_icb_cmd_read, m1_icb_rsp_valid, m1_icb_rsp_ready, m1_icb_rsp_err;
  logic [31:0] m1_icb_cmd_addr, m1_icb_cmd_wdata, m1_icb_rsp_rdata;
  logic [3:0] m1_icb_cmd_wmask;
  logic s_icb_cmd_valid, s_icb_cmd_ready, s_icb_cmd_read, s_icb_rsp_valid, s_icb_rsp_ready, s_icb_rsp_err;
  logic [31:0] s_icb_cmd_addr, s_icb_cmd_wdata, s_icb_rsp_rdata;
  logic [3:0] s_icb_cmd_wmask;
  logic timeout_o;

  icb_2m1s_arb #(.TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_icb_cmd_valid(m0_icb_cmd_valid), .m0_icb_cmd_ready(m0_icb_cmd_ready), .m0_icb_cmd_addr(m0_icb_cmd_addr),
    .m0_icb_cmd_read(m0_icb_cmd_read), .m0_icb_cmd_wdata(m0_icb_cmd_wdata), .m0_icb_cmd_wmask(m0_icb_cmd_wmask),
    .m0_icb_rsp_valid(m0_icb_rsp_valid), .m0_icb_rsp_ready(m0_icb_rsp_ready), .m0_icb_rsp_err(m0_icb_rsp_err),
    .m0_icb_rsp_rdata(m0_icb_rsp_rdata),
    .m1_icb_cmd_valid(m1_icb_cmd_valid), .m1_icb_cmd_ready(m1_icb_cmd_ready), .m1_icb_cmd_addr(m1_icb_cmd_addr),
    .m1_icb_cmd_read(m1_icb_cmd_read), .m1_icb_cmd_wdata(m1_icb_cmd_wdata), .m1_icb_cmd_wmask(m1_icb_cmd_wmask),
    .m1_icb_rsp_valid(m1_icb_rsp_valid), .m1_icb_rsp_ready(m1_icb_rsp_ready), .m1_icb_rsp_err(m1_icb_rsp_err),
    .m1_icb_rsp_rdata(m1_icb_rsp_rdata),
    .s_icb_cmd_valid(s_icb_cmd_valid), .s_icb_cmd_ready(s_icb_cmd_ready), .s_icb_cmd_addr(s_icb_cmd_addr),
    .s_icb_cmd_read(s_icb_cmd_read), .s_icb_cmd_wdata(s_icb_cmd_wdata), .s_icb_cmd_wmask(s_icb_cmd_wmask),
    .s_icb_rsp_valid(s_icb_rsp_valid), .s_icb_rsp_ready(s_icb_rsp_ready), .s_icb_rsp_err(s_icb_rsp_err),
    .s_icb_rsp_rdata(s_icb_rsp_rdata),
    .timeout_o(timeout_o)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;
  int cyc = 0, hs_cyc = 0, to_cnt = 0, stray = 0;
  int slv_lat = 1;
  bit slv_busy = 0;
  cmd_t mq0[$], mq1[$], exp_cmd[$];
  rsp_t exp_r0[$], exp_r1[$];

  task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Call order is the expected grant order at the slave.
  task automatic issue(input bit m, input logic [31:0] addr, input logic rd, input logic [31:0] wd,
                       input logic [3:0] wm, input bit timeout);
    cmd_t c = {addr, rd, wd, wm};
    rsp_t r = timeout ? {1'b1, 32'h0} : {addr[0], addr};
    if (m) begin mq1.push_back(c); exp_r1.push_back(r); end
    else begin mq0.push_back(c); exp_r0.push_back(r); end
    exp_cmd.push_back(c);
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_cmd.size() + exp_r0.size() + exp_r1.size() != 0 || slv_busy) && n < 200) begin
      @(posedge clk);
      n++;
    end
    chk("drain", exp_cmd.size() + exp_r0.size() + exp_r1.size() + int'(slv_busy), 0);
    repeat (2) @(posedge clk);
    #2;
  endtask

  always @(posedge clk) cyc++;

  always @(negedge clk) if (rst_n) begin
    if (s_icb_cmd_valid && s_icb_cmd_ready) begin
      hs_cyc = cyc;
      if (exp_cmd.size() == 0) chk("s_cmd_unexp", exp_cmd.size(), 1);
      else chk("s_cmd", {s_icb_cmd_addr, s_icb_cmd_read, s_icb_cmd_wdata, s_icb_cmd_wmask}, exp_cmd.pop_front());
    end
    if (m0_icb_rsp_valid && m0_icb_rsp_ready) begin
      if (exp_r0.size() == 0) chk("m0_rsp_unexp", exp_r0.size(), 1);
      else chk("m0_rsp", {m0_icb_rsp_err, m0_icb_rsp_rdata}, exp_r0.pop_front());
    end
    if (m1_icb_rsp_valid && m1_icb_rsp_ready) begin
      if (exp_r1.size() == 0) chk("m1_rsp_unexp", exp_r1.size(), 1);
      else chk("m1_rsp", {m1_icb_rsp_err, m1_icb_rsp_rdata}, exp_r1.pop_front());
    end
    if (timeout_o) begin
      to_cnt++;
      chk("to_cycle", cyc - hs_cyc, TO);
    end
    if ((m0_icb_cmd_ready && !m0_icb_cmd_valid) || (m1_icb_cmd_ready && !m1_icb_cmd_valid) ||
        (m0_icb_cmd_ready && m1_icb_cmd_ready)) stray++;
  end

  initial begin : masters
    cmd_t c;
    bit h0, h1;
    m0_icb_cmd_valid = 0; {m0_icb_cmd_addr, m0_icb_cmd_read, m0_icb_cmd_wdata, m0_icb_cmd_wmask} = '0;
    m1_icb_cmd_valid = 0; {m1_icb_cmd_addr, m1_icb_cmd_read, m1_icb_cmd_wdata, m1_icb_cmd_wmask} = '0;
    forever begin
      @(negedge clk);
      h0 = m0_icb_cmd_valid && m0_icb_cmd_ready;
      h1 = m1_icb_cmd_valid && m1_icb_cmd_ready;
      @(posedge clk);
      #1;
      if (h0) m0_icb_cmd_valid = 0;
      if (h1) m1_icb_cmd_valid = 0;
      if (!m0_icb_cmd_valid && mq0.size() > 0) begin
        c = mq0.pop_front();
        {m0_icb_cmd_addr, m0_icb_cmd_read, m0_icb_cmd_wdata, m0_icb_cmd_wmask} = c;
        m0_icb_cmd_valid = 1;
      end
      if (!m1_icb_cmd_valid && mq1.size() > 0) begin
        c = mq1.pop_front();
        {m1_icb_cmd_addr, m1_icb_cmd_read, m1_icb_cmd_wdata, m1_icb_cmd_wmask} = c;
        m1_icb_cmd_valid = 1;
      end
    end
  end

  // Slave: answers slv_lat cycles after acceptance (negative = never answers).
  initial begin : slave
    int lat, w;
    logic [31:0] a;
    s_icb_rsp_valid = 0; s_icb_rsp_err = 0; s_icb_rsp_rdata = 0;
    forever begin
      @(negedge clk);
      if (rst_n && s_icb_cmd_valid && s_icb_cmd_ready && slv_lat >= 0) begin
        lat = slv_lat;
        a = s_icb_cmd_addr;
        slv_busy = 1;
        repeat (lat) @(posedge clk);
        #1;
        s_icb_rsp_valid = 1; s_icb_rsp_err = a[0]; s_icb_rsp_rdata = a;
        w = 0;
        do begin @(negedge clk); w++; end while (!s_icb_rsp_ready && w < 50);
        chk("slv_rsp_taken", s_icb_rsp_ready, 1);
        @(posedge clk);
        #1;
        s_icb_rsp_valid = 0;
        slv_busy = 0;
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : main
    int c0, n;
    m0_icb_rsp_ready = 1; m1_icb_rsp_ready = 1; s_icb_cmd_ready = 1;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_s_valid", s_icb_cmd_valid, 0);
    chk("rst_cmd_ready", {m0_icb_cmd_ready, m1_icb_cmd_ready}, 0);
    chk("rst_rsp_valid", {m0_icb_rsp_valid, m1_icb_rsp_valid}, 0);
    chk("rst_timeout", timeout_o, 0);
    rst_n = 1;
    repeat (2) @(posedge clk);
    #2;
    // m1 alone, write, 3-cycle slave
    slv_lat = 3;
    issue(1, 32'h10, 0, 32'h1234_5678, 4'hF, 0);
    drain();
    // both masters continuously valid, 1-cycle slave: m0, m1, m0, m1
    slv_lat = 1;
    for (int i = 0; i < 4; i++) issue(i[0], i[0] ? 32'hB1 : 32'hA0, 1, 32'(i), 4'h0, 0);
    drain();
    // silent slave: watchdog, error to m0, late response absorbed
    slv_lat = 12;
    c0 = to_cnt;
    issue(0, 32'h40, 1, 32'h0, 4'h0, 1);
    drain();
    chk("to_pulses", to_cnt - c0, 1);
    // slave back-pressure holds the grant on m0 although m1 would win a tie now
    slv_lat = 1;
    s_icb_cmd_ready = 0;
    issue(0, 32'hC0, 0, 32'hCAFE, 4'h3, 0);
    @(posedge clk);
    #2;
    issue(1, 32'hD0, 0, 32'hBEEF, 4'hC, 0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("lock_cmd", {s_icb_cmd_valid, s_icb_cmd_addr, s_icb_cmd_wdata}, {1'b1, 32'hC0, 32'hCAFE});
    end
    @(posedge clk);
    #2;
    s_icb_cmd_ready = 1;
    drain();
    // response on the final count wins over the watchdog
    slv_lat = TO;
    c0 = to_cnt;
    issue(1, 32'h20, 1, 32'h0, 4'h0, 0);
    drain();
    chk("coinc_no_to", to_cnt - c0, 0);
    // reset while waiting for a response that never comes
    slv_lat = -1;
    issue(0, 32'h30, 1, 32'h0, 4'h0, 0);
    n = 0;
    while (exp_cmd.size() != 0 && n < 50) begin @(posedge clk); n++; end
    chk("abort_accepted", exp_cmd.size(), 0);
    repeat (2) @(posedge clk);
    #3;
    rst_n = 0;
    #1;
    chk("mid_rst_s_valid", s_icb_cmd_valid, 0);
    chk("mid_rst_rsp_valid", {m0_icb_rsp_valid, m1_icb_rsp_valid, timeout_o}, 0);
    chk("mid_rst_rsp_ready", s_icb_rsp_ready, 1);
    exp_r0.delete();
    slv_lat = 1;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1;
    @(posedge clk);
    #2;
    issue(0, 32'hA4, 1, 32'h0, 4'h0, 0);
    issue(1, 32'hB4, 1, 32'h0, 4'h0, 0);
    drain();
    chk("stray_cmd_ready", stray, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
